// File: rtl/sprot_seq_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : sprot_seq_checker_if
// Brief    : Strobe inputs and status outputs of the sprot sequence checker.
// Revision : 1.0 - initial release
// ============================================================================
interface sprot_seq_checker_if #(
  parameter int NUM_CH    = 2,
  parameter int NUM_STEPS = 2,
  parameter int CNT_W     = 8
);
  logic [NUM_CH-1:0]           start;
  logic [NUM_CH*NUM_STEPS-1:0] phase;
  logic                        strict;
  logic                        cnt_clr;
  logic [NUM_CH-1:0]           xfer_end;
  logic [NUM_CH-1:0]           prot_err;
  logic [2*NUM_CH-1:0]         err_code;
  logic [NUM_CH-1:0]           busy;
  logic [CNT_W-1:0]            err_cnt;

  modport master (
    output start, phase, strict, cnt_clr,
    input  xfer_end, prot_err, err_code, busy, err_cnt
  );

  modport slave (
    input  start, phase, strict, cnt_clr,
    output xfer_end, prot_err, err_code, busy, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sprot_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : sprot_seq_checker
// Brief    : Per-channel start/phase sequence monitor with error counter.
// Revision : 1.0 - initial release
// ============================================================================
module sprot_seq_checker #(
  parameter int NUM_CH    = 2,
  parameter int NUM_STEPS = 2,
  parameter int MAX_GAP   = 1,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  sprot_seq_checker_if.slave bus
);
  localparam int c_IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int c_GAP_W = $clog2(MAX_GAP + 1);
  localparam int c_SUM_W = CNT_W + $clog2(NUM_CH + 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  logic [NUM_CH-1:0] w_perr_nxt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t               r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_GAP_W-1:0]   r_gap;
    logic                 r_xend;
    logic                 r_perr;
    logic [1:0]           r_code;
    logic [NUM_STEPS-1:0] w_ph;
    logic [NUM_STEPS-1:0] w_sel;
    logic                 w_active;
    logic                 w_hit;
    logic                 w_other;
    logic                 w_last;
    logic                 w_gap_end;

    assign w_ph      = bus.phase[c*NUM_STEPS +: NUM_STEPS];
    assign w_sel     = NUM_STEPS'(1) << r_idx;
    assign w_active  = (r_state == S_ACTIVE);
    assign w_hit     = |(w_ph & w_sel);
    assign w_other   = |(w_ph & ~w_sel);
    assign w_last    = (r_idx == c_IDX_W'(NUM_STEPS - 1));
    assign w_gap_end = (r_gap == c_GAP_W'(MAX_GAP));

    // Error pulse mirrors the priority order of the ACTIVE branch below.
    assign w_perr_nxt[c] = w_active &
                           (bus.start[c] | (bus.strict & w_other) | (~w_hit & w_gap_end));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_idx   <= '0;
        r_gap   <= c_GAP_W'(1);
        r_xend  <= 1'b0;
        r_perr  <= 1'b0;
        r_code  <= 2'd0;
      end else begin
        r_xend <= 1'b0;
        r_perr <= w_perr_nxt[c];
        case (r_state)
          S_IDLE: begin
            if (bus.start[c]) begin
              r_state <= S_ACTIVE;
              r_idx   <= '0;
              r_gap   <= c_GAP_W'(1);
            end
          end
          S_ACTIVE: begin
            if (bus.start[c]) begin
              r_idx  <= '0;
              r_gap  <= c_GAP_W'(1);
              r_code <= 2'd3;
            end else if (bus.strict && w_other) begin
              r_code  <= 2'd2;
              r_state <= S_IDLE;
            end else if (w_hit) begin
              if (w_last) begin
                r_xend  <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_idx <= r_idx + c_IDX_W'(1);
                r_gap <= c_GAP_W'(1);
              end
            end else if (w_gap_end) begin
              r_code  <= 2'd1;
              r_state <= S_IDLE;
            end else begin
              r_gap <= r_gap + c_GAP_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

    assign bus.xfer_end[c]         = r_xend;
    assign bus.prot_err[c]         = r_perr;
    assign bus.err_code[2*c +: 2]  = r_code;
    assign bus.busy[c]             = w_active;
  end

  logic [c_SUM_W-1:0] w_pop;
  logic [c_SUM_W-1:0] w_sum;
  logic [CNT_W-1:0]   r_err_cnt;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pop = w_pop + c_SUM_W'(w_perr_nxt[i]);
    end
  end

  assign w_sum = c_SUM_W'(r_err_cnt) + w_pop;

  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      r_err_cnt <= '0;
    end else if (w_sum > c_SUM_W'(c_CNT_MAX)) begin
      r_err_cnt <= c_CNT_MAX;
    end else begin
      r_err_cnt <= w_sum[CNT_W-1:0];
    end
  end

  assign bus.err_cnt = r_err_cnt;
endmodule
`default_nettype wire

// File: tb/tb_sprot_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprot_seq_checker
// Brief    : Scoreboard bench with a transaction-level model of the checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprot_seq_checker;
  localparam int NCH  = 2;
  localparam int NST  = 3;
  localparam int MG   = 2;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprot_seq_checker_if #(.NUM_CH(NCH), .NUM_STEPS(NST), .CNT_W(CW)) bus ();

  sprot_seq_checker #(
    .NUM_CH(NCH), .NUM_STEPS(NST), .MAX_GAP(MG), .CNT_W(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [NCH-1:0]   xe;
    logic [NCH-1:0]   pe;
    logic [NCH-1:0]   busy;
    logic [2*NCH-1:0] code;
    int               cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Model view of a channel: in a transfer or not, which phase is awaited,
  // and how many edges have elapsed since the last accepted event.
  bit       m_act[NCH];
  int       m_step[NCH];
  int       m_since[NCH];
  int       m_code[NCH];
  int       m_cnt;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [NCH*NST-1:0] ph(int c, int k);
    logic [NCH*NST-1:0] v;
    v = '0;
    v[c*NST + k] = 1'b1;
    return v;
  endfunction

  task automatic apply(bit r, logic [NCH-1:0] st, logic [NCH*NST-1:0] p, bit s, bit clr);
    exp_t e;
    int   npe;
    logic [NST-1:0] cp;
    @(negedge clk);
    rst = r; bus.start = st; bus.phase = p; bus.strict = s; bus.cnt_clr = clr;
    e.xe = '0; e.pe = '0; e.busy = '0; e.code = '0;
    npe = 0;
    if (r) begin
      for (int c = 0; c < NCH; c++) begin
        m_act[c] = 0; m_code[c] = 0;
      end
      m_cnt = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        cp = p[c*NST +: NST];
        if (!m_act[c]) begin
          if (st[c]) begin m_act[c] = 1; m_step[c] = 0; m_since[c] = 0; end
        end else if (st[c]) begin
          e.pe[c] = 1; m_code[c] = 3; m_step[c] = 0; m_since[c] = 0;
        end else if (s && ((32'(cp) & ~(32'd1 << m_step[c])) != 0)) begin
          e.pe[c] = 1; m_code[c] = 2; m_act[c] = 0;
        end else if (cp[m_step[c]]) begin
          if (m_step[c] == NST - 1) begin e.xe[c] = 1; m_act[c] = 0; end
          else begin m_step[c]++; m_since[c] = 0; end
        end else if (m_since[c] + 1 >= MG) begin
          e.pe[c] = 1; m_code[c] = 1; m_act[c] = 0;
        end else begin
          m_since[c]++;
        end
        npe += int'(e.pe[c]);
      end
      if (clr) m_cnt = 0;
      else     m_cnt = (m_cnt + npe > CMAX) ? CMAX : m_cnt + npe;
    end
    for (int c = 0; c < NCH; c++) begin
      e.busy[c] = m_act[c];
      e.code[2*c +: 2] = 2'(m_code[c]);
    end
    e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) apply(0, '0, '0, 0, 0);
  endtask

  // Monitor: the DUT presents a full status word every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("xfer_end", 32'(bus.xfer_end), 32'(e.xe));
        chk("prot_err", 32'(bus.prot_err), 32'(e.pe));
        chk("busy",     32'(bus.busy),     32'(e.busy));
        chk("err_code", 32'(bus.err_code), 32'(e.code));
        chk("err_cnt",  32'(bus.err_cnt),  32'(e.cnt));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0]     st;
    logic [NCH*NST-1:0] p;
    rst = 1'b1; bus.start = '0; bus.phase = '0; bus.strict = 1'b0; bus.cnt_clr = 1'b0;
    apply(1, '0, '0, 0, 0);
    apply(1, '0, '0, 0, 0);
    // clean transfer on ch0
    apply(0, 2'b01, '0, 0, 0);
    apply(0, '0, ph(0, 0), 0, 0);
    apply(0, '0, ph(0, 1), 0, 0);
    apply(0, '0, ph(0, 2), 0, 0);
    idle(2);
    // timeout on ch1, then phases at the widest legal spacing
    apply(0, 2'b10, '0, 0, 0);
    idle(3);
    apply(0, 2'b10, '0, 0, 0);
    idle(1);
    apply(0, '0, ph(1, 0), 0, 0);
    idle(1);
    apply(0, '0, ph(1, 1), 0, 0);
    apply(0, '0, ph(1, 2), 0, 0);
    idle(1);
    // out-of-order phases, strict then relaxed
    apply(0, 2'b01, '0, 1, 0);
    apply(0, '0, ph(0, 0) | ph(0, 1), 1, 0);
    idle(1);
    apply(0, 2'b01, '0, 0, 0);
    apply(0, '0, ph(0, 0) | ph(0, 1), 0, 0);
    apply(0, '0, ph(0, 1), 0, 0);
    apply(0, '0, ph(0, 2), 0, 0);
    // restart then complete; phase bits in IDLE are ignored
    apply(0, '0, ph(1, 0), 1, 0);
    apply(0, 2'b11, '0, 0, 0);
    apply(0, 2'b01, '0, 0, 0);
    apply(0, '0, ph(0, 0), 0, 0);
    apply(0, '0, ph(0, 1), 0, 0);
    apply(0, '0, ph(0, 2), 0, 0);
    idle(3);
    // simultaneous timeouts drive the counter to saturation
    for (int i = 0; i < 4; i++) begin
      apply(0, 2'b11, '0, 0, 0);
      idle(2);
    end
    apply(0, 2'b11, '0, 0, 0);
    apply(0, '0, '0, 0, 0);
    apply(0, '0, '0, 0, 1);
    idle(1);
    // reset mid-transfer, then a normal transfer
    apply(0, 2'b01, '0, 0, 0);
    apply(0, '0, ph(0, 0), 0, 0);
    apply(1, '0, ph(0, 1), 0, 0);
    idle(1);
    apply(0, 2'b01, '0, 0, 0);
    apply(0, '0, ph(0, 0), 0, 0);
    apply(0, '0, ph(0, 1), 0, 0);
    apply(0, '0, ph(0, 2), 0, 0);
    // randomized traffic biased toward legal sequences
    for (int n = 0; n < 2500; n++) begin
      st = '0;
      p  = '0;
      for (int c = 0; c < NCH; c++) begin
        st[c] = ($urandom_range(0, 9) == 0);
        if (m_act[c] && $urandom_range(0, 9) < 6) p[c*NST + m_step[c]] = 1'b1;
        for (int k = 0; k < NST; k++)
          if ($urandom_range(0, 19) == 0) p[c*NST + k] = 1'b1;
      end
      apply($urandom_range(0, 299) == 0, st, p,
            $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
    end
    idle(3);
    @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
